// File: rtl/tanh4_rr_scheduler.sv
// Round-robin arbiter in front of one shared 4-bit tanh lookup core.
// Each result is tagged with its requester id and queued in a 2-entry in-order FIFO.
module tanh4_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [3:0]        out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [1:0]     count_q, count_d;
  logic [3:0]     head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [IDW-1:0] head_id_q, head_id_d, tail_id_q, tail_id_d;

  logic [NREQ-1:0] rot;
  logic [IDW:0]    sum;
  logic            found;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  next_ptr;
  logic [3:0]      core_in, core_out;
  logic            space, pop, push;

  // Rotate the valid vector so bit 0 is the requester at ptr.
  always_comb begin
    rot      = NREQ'({req_valid, req_valid} >> ptr_q);
    found    = 1'b0;
    grant_id = '0;
    sum      = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        grant_id = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    core_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) core_in = req_data[4*i +: 4];
    end
  end

  // The single shared approximate-tanh core.
  always_comb begin
    core_out = '0;
    case (core_in)
      4'd0:  core_out = 4'd0;
      4'd1:  core_out = 4'd3;
      4'd2:  core_out = 4'd12;
      4'd3:  core_out = 4'd3;
      4'd4:  core_out = 4'd0;
      4'd5:  core_out = 4'd3;
      4'd6:  core_out = 4'd12;
      4'd7:  core_out = 4'd7;
      4'd8:  core_out = 4'd0;
      4'd9:  core_out = 4'd3;
      4'd10: core_out = 4'd12;
      4'd11: core_out = 4'd11;
      4'd12: core_out = 4'd4;
      4'd13: core_out = 4'd3;
      4'd14: core_out = 4'd12;
      4'd15: core_out = 4'd15;
      default: core_out = '0;
    endcase
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_id    = head_id_q;
  assign pop       = out_valid && out_ready && !rst;
  assign space     = (count_q < 2'd2) || (out_valid && out_ready);
  assign push      = found && space && !rst;
  assign next_ptr  = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = push && (grant_id == IDW'(i));
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    head_data_d = head_data_q;
    head_id_d   = head_id_q;
    tail_data_d = tail_data_q;
    tail_id_d   = tail_id_q;
    // With a single entry the head is left in place on pop, so it holds its last value.
    if (pop && count_q == 2'd2) begin
      head_data_d = tail_data_q;
      head_id_d   = tail_id_q;
    end
    if (push) begin
      ptr_d = next_ptr;
      if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
        head_data_d = core_out;
        head_id_d   = grant_id;
      end else begin
        tail_data_d = core_out;
        tail_id_d   = grant_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      head_data_q <= '0;
      head_id_q   <= '0;
      tail_data_q <= '0;
      tail_id_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_id_q   <= head_id_d;
      tail_data_q <= tail_data_d;
      tail_id_q   <= tail_id_d;
    end
  end

endmodule

// File: tb/tb_tanh4_rr_scheduler.sv
// Directed bench for tanh4_rr_scheduler with a reference model and result scoreboard.
module tb_tanh4_rr_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [3:0] d; logic [1:0] id; } ent_t;
  ent_t m_q[$];
  int   m_ptr = 0;
  int   core_tab[16] = '{0,3,12,3,0,3,12,7,0,3,12,11,4,3,12,15};

  tanh4_rr_scheduler #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model checks at negedge, then advance model state after the edge.
  task automatic cyc();
    logic [3:0]  exp_rr;
    logic [3:0]  rv;
    logic [15:0] sh;
    int          g;
    int          idx;
    bit          sp;
    bit          do_pop;
    ent_t        e;
    @(negedge clk);
    exp_rr = '0;
    g  = -1;
    rv = req_valid;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (g < 0 && rv[idx[1:0]]) g = idx;
    end
    sp = (m_q.size() < 2) || (m_q.size() != 0 && out_ready);
    if (!rst && g >= 0 && sp) exp_rr[g[1:0]] = 1'b1;
    else g = -1;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    do_pop = !rst && out_ready && m_q.size() != 0;
    if (do_pop) begin
      chk("head_data", 32'(out_data), 32'(m_q[0].d));
      chk("head_id", 32'(out_id), 32'(m_q[0].id));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_q.delete();
      m_ptr = 0;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (g >= 0) begin
        sh   = req_data >> (4 * g);
        e.d  = 4'(core_tab[sh[3:0]]);
        e.id = g[1:0];
        m_q.push_back(e);
        m_ptr = (g + 1) % 4;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset then idle
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0100;
    req_data  = 16'h0B00;
    #1;
    chk("first_grant", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = '0;
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'd11);
    chk("first_id", 32'(out_id), 32'd2);
    out_ready = 1'b1;
    cyc();
    chk("first_drained", 32'(out_valid), 32'd0);

    // Exhaustive core function through requester 0
    for (int v = 0; v < 16; v++) begin
      req_valid = 4'b0001;
      req_data  = 16'(v);
      cyc();
      chk("exh_valid", 32'(out_valid), 32'd1);
      chk("exh_data", 32'(out_data), 32'(core_tab[v]));
      chk("exh_id", 32'(out_id), 32'd0);
    end
    req_valid = '0;
    cyc();
    cyc();

    // Round-robin fairness
    do_reset();
    req_valid = 4'b1111;
    req_data  = 16'hFEDC;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr_id", 32'(out_id), 32'(k % 4));
      chk("rr_data", 32'(out_data), 32'(core_tab[12 + k % 4]));
    end
    req_valid = '0;
    cyc();
    cyc();

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b1010;
    req_data  = 16'h9050;
    cyc();
    cyc();
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    chk("bp_head_id", 32'(out_id), 32'd1);
    cyc();
    out_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'b0010);
    cyc();
    chk("bp_next_head", 32'(out_id), 32'd3);
    req_valid = '0;
    cyc();
    cyc();
    cyc();

    // Reset mid-stream
    out_ready = 1'b0;
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    cyc();
    cyc();
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    do_reset();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    req_valid = 4'b1100;
    #1;
    chk("mid_rst_grant", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = '0;
    out_ready = 1'b1;
    cyc();
    cyc();

    // Wrap with sparse valid
    do_reset();
    req_valid = 4'b1001;
    req_data  = 16'h2007;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("wrap_id", 32'(out_id), (k % 2 == 0) ? 32'd0 : 32'd3);
    end
    req_valid = '0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tanh4_rr_scheduler.md
# tanh4_rr_scheduler

Round-robin scheduler that shares one combinational 4-bit approximate tanh core (Config3 approximation) among NREQ requesters. Each cycle it grants at most one valid requester, drives the core with that requester's operand, and captures the result and requester id into a 2-entry output FIFO with valid/ready backpressure. It sits between the activation-function requesters of a small NN datapath and a single downstream consumer.

## Interface
- NREQ, 4, number of requesters, 2..16
- IDW, 2, requester-id width, must satisfy 2**IDW >= NREQ
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester operand valid
- req_data  input  4*NREQ  operands; requester i uses bits [4i+3:4i]
- req_ready  output  NREQ  one-hot-or-zero grant/accept
- out_valid  output  1  FIFO head valid
- out_data  output  4  tanh result at FIFO head
- out_id  output  IDW  requester index of FIFO head
- out_ready  input  1  consumer accepts head

## Operation
- Shared core function, In -> Out, for In = 0..15: 0,3,12,3,0,3,12,7,0,3,12,11,4,3,12,15. The core is instantiated exactly once; no per-requester copies.
- Round-robin pointer ptr (IDW bits, reset 0). The search order is ptr, ptr+1, ..., wrapping modulo NREQ. The first requester with req_valid=1 is the candidate g.
- space = (fifo count < 2) OR (out_valid AND out_ready).
- req_ready[g] = space. All other req_ready bits are 0. req_ready is combinational from req_valid, ptr and FIFO state. Requesters must not make req_valid depend on req_ready.
- Accept (req_valid[g] AND req_ready[g]):
  - push {core(req_data[g]), g} into the FIFO;
  - ptr <= (g+1) mod NREQ.
- With no accept, ptr holds.
- Pop when out_valid AND out_ready. The head advances.
- Push and pop in the same cycle are both performed. The count is unchanged and ordering is preserved.
- FIFO: 2 entries, in order. out_data/out_id come from the head register. out_valid = (count != 0).
- Requesters keep req_valid/req_data stable until accepted; the block does not check this.

## Timing
- Reset values: ptr=0, FIFO count=0, out_valid=0, out_data=0, out_id=0, req_ready=0 during the rst cycle.
- Latency: accept at edge t gives out_valid=1 from cycle t+1 when the FIFO was empty.
- Throughput: one result per cycle sustained while out_ready=1.
- Full (count=2, out_ready=0): all req_ready=0 and ptr frozen.
- Full with out_ready=1: an accept is allowed in the same cycle.
- Empty: out_valid=0, and out_data/out_id hold their last values (don't-care to the consumer).
- Wrap: g = NREQ-1 sets ptr to 0.
- rst asserted mid-operation clears the FIFO and ptr on that edge. In-flight results are discarded and no partial pop occurs.
- No combinational path from out_ready to out_valid/out_data. The only path from out_ready to req_ready is through space.

## Test plan
- Reset then idle: after rst, out_valid=0, req_ready=0. Then req_valid[2]=1, data=4'd11: req_ready=4'b0100. Next cycle out_valid=1, out_data=11, out_id=2.
- Exhaustive function check: requester 0 alone, data 0..15 back-to-back, out_ready=1 -> outputs 0,3,12,3,0,3,12,7,0,3,12,11,4,3,12,15 on consecutive cycles with id 0.
- Round-robin fairness: all four valid continuously, data i=4'd(12+i), out_ready=1 -> ids 0,1,2,3,0,... with data 4,3,12,15 repeating. No requester is granted twice before the others are granted once.
- Backpressure: out_ready=0 with requesters 1 and 3 valid -> two accepts (ids 1,3), then req_ready=0 and ptr held. Raising out_ready pops id 1 and accepts the next grant (id 1 again, ptr=0 search order from 0 gives 1) in the same cycle.
- Reset mid-stream: FIFO holding 2 entries, assert rst one cycle -> out_valid=0 next cycle, ptr=0. First post-reset grant goes to the lowest valid index.
- Wrap with sparse valid: only requesters 3 and 0 valid -> grants alternate 3,0,3,0 starting from 0 after reset (0,3,0,3).
